// File: rtl/alu_pipe_pkg.sv
// Shared constants and the opcode encoding for the two-stage integer ALU pipeline.
package alu_pipe_pkg;

  localparam int ROB_SIZE     = 4;  // ROB tag width
  localparam int RS_TYPE_SIZE = 4;  // opcode width
  localparam int XLEN         = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Pure combinational result function: arithmetic, logic, shifts and compare/branch flags.
module alu_core
  import alu_pipe_pkg::*;
(
  input  alu_op_e          op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  output logic [XLEN-1:0]  result_o
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;
  logic       eq;

  assign shamt = b_i[4:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;
  assign eq    = a_i == b_i;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {31'd0, lt_s};
      ALU_SLTU: result_o = {31'd0, lt_u};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_BEQ:  result_o = {31'd0, eq};
      ALU_BNE:  result_o = {31'd0, ~eq};
      ALU_BLT:  result_o = {31'd0, lt_s};
      ALU_BGE:  result_o = {31'd0, ~lt_s};
      ALU_BLTU: result_o = {31'd0, lt_u};
      ALU_BGEU: result_o = {31'd0, ~lt_u};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline: E1 captures the issued op, E2 holds the result broadcast on the CDB.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int ROB_W = ROB_SIZE,
  parameter int OP_W  = RS_TYPE_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             rs_shot,
  input  logic [XLEN-1:0]  alu_r1,
  input  logic [XLEN-1:0]  alu_r2,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic [OP_W-1:0]  alu_work_type,
  output logic             alu_ready,
  output logic [ROB_W-1:0] inputalu_rob_id,
  output logic [XLEN-1:0]  alu_value,
  output logic [1:0]       alu_inflight
);

  logic             e1_vld_q, e1_vld_d;
  logic [XLEN-1:0]  e1_a_q, e1_a_d;
  logic [XLEN-1:0]  e1_b_q, e1_b_d;
  logic [OP_W-1:0]  e1_op_q, e1_op_d;
  logic [ROB_W-1:0] e1_tag_q, e1_tag_d;

  logic             e2_vld_q, e2_vld_d;
  logic [ROB_W-1:0] e2_tag_q, e2_tag_d;
  logic [XLEN-1:0]  e2_val_q, e2_val_d;

  logic [XLEN-1:0]  core_res;

  alu_core u_core (
    .op_i     (alu_op_e'(e1_op_q)),
    .a_i      (e1_a_q),
    .b_i      (e1_b_q),
    .result_o (core_res)
  );

  always_comb begin
    e1_vld_d = e1_vld_q;
    e1_a_d   = e1_a_q;
    e1_b_d   = e1_b_q;
    e1_op_d  = e1_op_q;
    e1_tag_d = e1_tag_q;
    e2_vld_d = e2_vld_q;
    e2_tag_d = e2_tag_q;
    e2_val_d = e2_val_q;

    if (rdy) begin
      if (clear) begin
        // Flush kills only the valid bits; payloads stay as they were.
        e1_vld_d = 1'b0;
        e2_vld_d = 1'b0;
      end else begin
        e1_vld_d = rs_shot;
        if (rs_shot) begin
          e1_a_d   = alu_r1;
          e1_b_d   = alu_r2;
          e1_op_d  = alu_work_type;
          e1_tag_d = alu_rob_id;
        end
        e2_vld_d = e1_vld_q;
        if (e1_vld_q) begin
          e2_tag_d = e1_tag_q;
          e2_val_d = core_res;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: datapath registers are reset too, so the broadcast bus reads zero while in reset.
      e1_vld_q <= 1'b0;
      e1_a_q   <= '0;
      e1_b_q   <= '0;
      e1_op_q  <= '0;
      e1_tag_q <= '0;
      e2_vld_q <= 1'b0;
      e2_tag_q <= '0;
      e2_val_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all of them update on the same edge.
      e1_vld_q <= e1_vld_d;
      e1_a_q   <= e1_a_d;
      e1_b_q   <= e1_b_d;
      e1_op_q  <= e1_op_d;
      e1_tag_q <= e1_tag_d;
      e2_vld_q <= e2_vld_d;
      e2_tag_q <= e2_tag_d;
      e2_val_q <= e2_val_d;
    end
  end

  assign alu_ready       = e2_vld_q;
  assign inputalu_rob_id = e2_tag_q;
  assign alu_value       = e2_val_q;
  assign alu_inflight    = {1'b0, e1_vld_q} + {1'b0, e2_vld_q};

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized plus directed bench for alu_pipe against a queue-based behavioural model.
module tb_alu_pipe;

  localparam int ROB_W = 4;
  localparam int OP_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             rdy = 1'b0;
  logic             clear = 1'b0;
  logic             rs_shot = 1'b0;
  logic [31:0]      alu_r1 = '0;
  logic [31:0]      alu_r2 = '0;
  logic [ROB_W-1:0] alu_rob_id = '0;
  logic [OP_W-1:0]  alu_work_type = '0;
  logic             alu_ready;
  logic [ROB_W-1:0] inputalu_rob_id;
  logic [31:0]      alu_value;
  logic [1:0]       alu_inflight;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  alu_pipe #(.ROB_W(ROB_W), .OP_W(OP_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .clear           (clear),
    .rs_shot         (rs_shot),
    .alu_r1          (alu_r1),
    .alu_r2          (alu_r2),
    .alu_rob_id      (alu_rob_id),
    .alu_work_type   (alu_work_type),
    .alu_ready       (alu_ready),
    .inputalu_rob_id (inputalu_rob_id),
    .alu_value       (alu_value),
    .alu_inflight    (alu_inflight)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the opcode table, using plain integer arithmetic.
  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sa_s, sb_s;
    logic [31:0] r;
    sa   = int'(b & 32'd31);
    sa_s = int'(a);
    sb_s = int'(b);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << sa;
      3:  return (sa_s < sb_s) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> sa;
      7: begin
        r = a >> sa;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sa);
        return r;
      end
      8:  return a | b;
      9:  return a & b;
      10: return (a == b) ? 32'd1 : 32'd0;
      11: return (a != b) ? 32'd1 : 32'd0;
      12: return (sa_s < sb_s) ? 32'd1 : 32'd0;
      13: return (sa_s >= sb_s) ? 32'd1 : 32'd0;
      14: return (a < b) ? 32'd1 : 32'd0;
      default: return (a >= b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Model: ops waiting one cycle to broadcast, plus the currently visible broadcast.
  typedef struct {
    logic [ROB_W-1:0] tag;
    logic [31:0]      val;
  } res_t;

  res_t             pend[$];
  logic             m_v;
  logic [ROB_W-1:0] m_tag;
  logic [31:0]      m_val;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend.delete();
      m_v   <= 1'b0;
      m_tag <= '0;
      m_val <= '0;
    end else if (rdy) begin
      if (clear) begin
        pend.delete();
        m_v <= 1'b0;
      end else begin
        if (pend.size() > 0) begin
          m_v   <= 1'b1;
          m_tag <= pend[0].tag;
          m_val <= pend[0].val;
          void'(pend.pop_front());
        end else begin
          m_v <= 1'b0;
        end
        if (rs_shot)
          pend.push_back('{alu_rob_id, alu_ref(int'(alu_work_type), alu_r1, alu_r2)});
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_ready",    32'(alu_ready),       32'(m_v));
      check("cmp_tag",      32'(inputalu_rob_id), 32'(m_tag));
      check("cmp_value",    alu_value,            m_val);
      check("cmp_inflight", 32'(alu_inflight),    32'(pend.size()) + 32'(m_v));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input bit shot, input int op, input logic [31:0] a, input logic [31:0] b,
                       input int tag);
    rs_shot       = shot;
    alu_work_type = OP_W'(op);
    alu_r1        = a;
    alu_r2        = b;
    alu_rob_id    = ROB_W'(tag);
  endtask

  task automatic run_op(input string name, input int op, input logic [31:0] a,
                        input logic [31:0] b, input int tag, input logic [31:0] exp);
    drive(1'b1, op, a, b, tag);
    tick();
    drive(1'b0, 0, '0, '0, 0);
    tick();
    check({name, "_ready"}, 32'(alu_ready), 32'd1);
    check({name, "_tag"},   32'(inputalu_rob_id), 32'(tag));
    check({name, "_value"}, alu_value, exp);
    tick();
    check({name, "_once"},  32'(alu_ready), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Pin the reference function on a few hand-computed cases.
    check("ref_sra",  alu_ref(7, 32'h8000_0000, 32'h21), 32'hC000_0000);
    check("ref_sub",  alu_ref(1, 32'd0, 32'd1),          32'hFFFF_FFFF);
    check("ref_slt",  alu_ref(3, 32'hFFFF_FFFF, 32'd0),  32'd1);
    check("ref_sltu", alu_ref(4, 32'hFFFF_FFFF, 32'd0),  32'd0);

    repeat (3) tick();
    check("reset_ready",    32'(alu_ready),       32'd0);
    check("reset_tag",      32'(inputalu_rob_id), 32'd0);
    check("reset_value",    alu_value,            32'd0);
    check("reset_inflight", 32'(alu_inflight),    32'd0);
    rst    = 1'b1;
    rdy    = 1'b1;
    cmp_en = 1'b1;
    tick();

    // ADD wraps, single-cycle broadcast two edges after issue.
    drive(1'b1, 0, 32'hFFFF_FFFF, 32'd1, 5);
    tick();
    check("add_e1_inflight", 32'(alu_inflight), 32'd1);
    check("add_e1_ready",    32'(alu_ready),    32'd0);
    drive(1'b0, 0, '0, '0, 0);
    tick();
    check("add_ready", 32'(alu_ready),       32'd1);
    check("add_tag",   32'(inputalu_rob_id), 32'd5);
    check("add_value", alu_value,            32'h0000_0000);
    tick();
    check("add_once",  32'(alu_ready),       32'd0);

    // Back-to-back SRA then SLTU.
    drive(1'b1, 7, 32'h8000_0000, 32'h21, 1);
    tick();
    drive(1'b1, 4, 32'd1, 32'hFFFF_FFFF, 2);
    tick();
    check("b2b_val0",     alu_value,         32'hC000_0000);
    check("b2b_inflight", 32'(alu_inflight), 32'd2);
    drive(1'b0, 0, '0, '0, 0);
    tick();
    check("b2b_ready1",   32'(alu_ready),       32'd1);
    check("b2b_tag1",     32'(inputalu_rob_id), 32'd2);
    check("b2b_val1",     alu_value,            32'h0000_0001);
    tick();
    check("b2b_done",     32'(alu_ready),       32'd0);

    run_op("blt",  12, 32'hFFFF_FFFF, 32'd0, 3, 32'd1);
    run_op("bgeu", 15, 32'hFFFF_FFFF, 32'd0, 4, 32'd1);
    run_op("beq",  10, 32'd7, 32'd7, 6, 32'd1);
    run_op("bne",  11, 32'd7, 32'd7, 7, 32'd0);

    // Flush with two ops in flight and a simultaneous shot.
    drive(1'b1, 0, 32'd1, 32'd2, 8);
    tick();
    drive(1'b1, 0, 32'd3, 32'd4, 9);
    tick();
    clear = 1'b1;
    drive(1'b1, 0, 32'd5, 32'd6, 10);
    tick();
    clear = 1'b0;
    drive(1'b0, 0, '0, '0, 0);
    check("clr_ready0",    32'(alu_ready),    32'd0);
    check("clr_inflight0", 32'(alu_inflight), 32'd0);
    tick();
    check("clr_ready1",    32'(alu_ready),    32'd0);
    check("clr_inflight1", 32'(alu_inflight), 32'd0);

    // Stall three cycles with an op in E1; the shot during the stall is ignored.
    drive(1'b1, 0, 32'd10, 32'd20, 9);
    tick();
    rdy = 1'b0;
    drive(1'b1, 5, 32'hFFFF, 32'h1, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready",    32'(alu_ready),    32'd0);
      check("stall_inflight", 32'(alu_inflight), 32'd1);
    end
    rdy = 1'b1;
    drive(1'b0, 0, '0, '0, 0);
    tick();
    check("stall_bcast", 32'(alu_ready),       32'd1);
    check("stall_tag",   32'(inputalu_rob_id), 32'd9);
    check("stall_value", alu_value,            32'd30);
    tick();

    // Asynchronous reset between edges while E2 is broadcasting.
    drive(1'b1, 8, 32'hF0, 32'h0F, 3);
    tick();
    drive(1'b0, 0, '0, '0, 0);
    tick();
    check("arst_pre_ready", 32'(alu_ready), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_ready",    32'(alu_ready),       32'd0);
    check("arst_tag",      32'(inputalu_rob_id), 32'd0);
    check("arst_value",    alu_value,            32'd0);
    check("arst_inflight", 32'(alu_inflight),    32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("arst_no_bcast", 32'(alu_ready), 32'd0);

    // Randomized traffic with stalls, flushes and one mid-cycle reset.
    for (int i = 0; i < 3000; i++) begin
      rdy   = ($urandom_range(0, 99) < 85);
      clear = ($urandom_range(0, 99) < 5);
      drive($urandom_range(0, 99) < 70, int'($urandom_range(0, 15)), pick(), pick(),
            int'($urandom_range(0, 15)));
      if (i == 1500) begin
        #3 rst = 1'b0;
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end

    rdy   = 1'b1;
    clear = 1'b0;
    drive(1'b0, 0, '0, '0, 0);
    repeat (3) tick();
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter ROB_W, default `robsize, meaning ROB tag width.
REQ-002 SHALL have parameter OP_W, default `rs_type_size (4), meaning operation code width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-006 SHALL have port clear  input  1  flush (mispredict); kills all in-flight ops.
REQ-007 SHALL have port rs_shot  input  1  issue strobe from reservation station.
REQ-008 SHALL have port alu_r1  input  32  operand 1.
REQ-009 SHALL have port alu_r2  input  32  operand 2.
REQ-010 SHALL have port alu_rob_id  input  ROB_W  destination ROB tag.
REQ-011 SHALL have port alu_work_type  input  OP_W  operation code.
REQ-012 SHALL have port alu_ready  output  1  result broadcast valid (CDB strobe).
REQ-013 SHALL have port inputalu_rob_id  output  ROB_W  tag of broadcast result.
REQ-014 SHALL have port alu_value  output  32  broadcast result.
REQ-015 SHALL have port alu_inflight  output  2  number of valid pipeline stages (0..2).

Function
REQ-016 SHALL be a 2-stage pipeline: stage E1 latches operands/op/tag on rs_shot; stage E2 latches computed result; alu_ready/inputalu_rob_id/alu_value driven directly from E2 registers.
REQ-017 SHALL give latency 2: rs_shot sampled at edge N -> alu_ready high for exactly one cycle after edge N+1.
REQ-018 SHALL accept one op per cycle with no backpressure; back-to-back issues produce back-to-back broadcasts in order.
REQ-019 SHALL encode ops: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
REQ-020 SHALL compute ADD/SUB modulo 2^32 (overflow discarded); shifts use alu_r2[4:0] only; SRA sign-extends.
REQ-021 SHALL treat SLT/BLT/BGE as signed, SLTU/BLTU/BGEU as unsigned; compare/branch ops return 32'd1 true, 32'd0 false.
REQ-022 SHALL, when clear is high on an edge with rdy high, invalidate E1 and E2 and ignore rs_shot of that same cycle; alu_ready low next cycle.
REQ-023 SHALL, when rdy is low, hold all registers including alu_ready; broadcast repeats visibly but represents one result (consumers gate with rdy).
REQ-024 SHALL keep alu_inflight = E1 valid + E2 valid, updated on same edges as valids.
REQ-025 SHALL hold value/tag registers unchanged when their stage is invalid (only valid bits cleared).

Reset
REQ-026 SHALL, on rst low (asynchronous, independent of clk/rdy), clear E1/E2 valid, alu_ready=0, inputalu_rob_id=0, alu_value=0, alu_inflight=0, all data registers 0.
REQ-027 SHALL discard any op in flight when reset asserts mid-operation; no broadcast after deassertion until a new rs_shot.
REQ-028 SHALL resume normal operation on the first rising edge after rst returns high.

Structure
REQ-029 SHALL take `robsize, `rs_type_size and the op code constants (ALU_ADD..ALU_BGEU) from shared const.v.
REQ-030 SHALL place the pure combinational result function in one sub-module alu_core (op, a, b -> 32-bit result); pipeline registers stay in alu_pipe.

Verification
REQ-031 SHALL cover: shot ADD r1=0xFFFFFFFF r2=1 tag=5 -> 2 cycles later alu_ready=1, tag 5, value 0x00000000, one cycle only.
REQ-032 SHALL cover: back-to-back SRA r1=0x80000000 r2=0x21 then SLTU r1=1 r2=0xFFFFFFFF -> consecutive broadcasts 0xC0000000 then 0x00000001, alu_inflight=2 between.
REQ-033 SHALL cover: BLT r1=0xFFFFFFFF r2=0 -> 1; BGEU same operands -> 1; BEQ 7,7 -> 1; BNE 7,7 -> 0.
REQ-034 SHALL cover: two ops in flight, clear pulsed with simultaneous rs_shot -> no alu_ready next 2 cycles, alu_inflight=0.
REQ-035 SHALL cover: rdy low for 3 cycles with op in E1 -> outputs frozen, broadcast appears after rdy returns, tag intact.
REQ-036 SHALL cover: rst asserted between clocks with op in E2 -> alu_ready drops immediately, outputs 0, no later broadcast.
